// File: rtl/rp_sd_arbiter.sv
// -----------------------------------------------------------------------------
// rp_sd_arbiter
//
// Round-robin arbiter between eight RP drives and a single sector engine.
// The arbiter scans the drive request lines, latches the operation and
// starting sector of the first requesting drive it finds, then hands the
// sector engine one sector at a time until the RH11 word count reaches zero,
// a per-sector timeout expires, or the operation turns out to be illegal.
// The served drive gets a one-cycle acknowledge, and scanning resumes at the
// next drive once the served drive drops its request.
//
// Ports
//   clk_i         system clock, the only clock
//   rst_ni        synchronous active-low reset
//   clr_i         massbus INIT, synchronous abort with the same effect as reset
//   rpSDREQ_i     per-drive request levels, held until acknowledged
//   rpSDOP_i      operation of drive sdSCAN_o (001 READ, 010 WRITE, 011 WRCHK)
//   rpSDLSA_i     linear sector address of drive sdSCAN_o
//   rhWCZ_i       RH11 word count zero
//   secDONE_i     sector engine one-cycle completion pulse
//   secREQ_o      sector transfer request level
//   secOP_o       latched operation for the sector engine
//   secLSA_o      current sector address for the sector engine
//   rpSDACK_o     one-hot one-cycle completion pulse to the served drive
//   sdSCAN_o      drive currently scanned or served
//   sdINCSECT_o   one-cycle pulse between sectors of a multi-sector transfer
//   sdREADOP_o    high while serving READ or WRCHK
//   sdTMO_o       sticky timeout flag
// -----------------------------------------------------------------------------
module rp_sd_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic [7:0]  rpSDREQ_i,
    input  logic [2:0]  rpSDOP_i,
    input  logic [20:0] rpSDLSA_i,
    input  logic        rhWCZ_i,
    input  logic        secDONE_i,
    output logic        secREQ_o,
    output logic [2:0]  secOP_o,
    output logic [20:0] secLSA_o,
    output logic [7:0]  rpSDACK_o,
    output logic [2:0]  sdSCAN_o,
    output logic        sdINCSECT_o,
    output logic        sdREADOP_o,
    output logic        sdTMO_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LATCH   = 3'd1,
        S_XFER    = 3'd2,
        S_NEXT    = 3'd3,
        S_ACK     = 3'd4,
        S_RELEASE = 3'd5
    } state_e;

    state_e      state_q;
    logic        secreq_q;
    logic [2:0]  secop_q;
    logic [20:0] seclsa_q;
    logic [7:0]  rpsdack_q;
    logic [2:0]  sdscan_q;
    logic        sdincsect_q;
    logic        sdreadop_q;
    logic        sdtmo_q;
    logic [23:0] tmo_cnt_q;   // XFER cycles already spent on the current sector

    logic        req_sel;
    logic [7:0]  ack_onehot;
    logic        op_legal;
    logic        op_is_read;
    logic        tmo_hit;

    assign req_sel    = rpSDREQ_i[sdscan_q];
    assign ack_onehot = 8'h01 << sdscan_q;
    assign op_legal   = (secop_q == 3'b001) || (secop_q == 3'b010) || (secop_q == 3'b011);
    assign op_is_read = (rpSDOP_i == 3'b001) || (rpSDOP_i == 3'b011);
    // The current XFER cycle is the TIMEOUT-th one for this sector.
    assign tmo_hit    = (tmo_cnt_q + 24'd1) == TIMEOUT;

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking assignments would let later branches see half-updated values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_q     <= S_IDLE;
            secreq_q    <= 1'b0;
            secop_q     <= 3'd0;
            seclsa_q    <= 21'd0;
            rpsdack_q   <= 8'd0;
            sdscan_q    <= 3'd0;
            sdincsect_q <= 1'b0;
            sdreadop_q  <= 1'b0;
            sdtmo_q     <= 1'b0;
            tmo_cnt_q   <= 24'd0;
        end else begin
            // Pulse outputs fall back to zero unless a transition raises them.
            rpsdack_q   <= 8'd0;
            sdincsect_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (req_sel) begin
                        // Op and address are captured on entry so secOP and
                        // sdREADOP are already valid while in LATCH.
                        secop_q    <= rpSDOP_i;
                        seclsa_q   <= rpSDLSA_i;
                        sdreadop_q <= op_is_read;
                        state_q    <= S_LATCH;
                    end else begin
                        sdscan_q   <= sdscan_q + 3'd1;
                    end
                end

                S_LATCH: begin
                    if (!op_legal) begin
                        rpsdack_q <= ack_onehot;
                        state_q   <= S_ACK;
                    end else begin
                        secreq_q  <= 1'b1;
                        tmo_cnt_q <= 24'd0;
                        state_q   <= S_XFER;
                    end
                end

                S_XFER: begin
                    // Completion is checked first so it beats a same-cycle timeout.
                    if (secDONE_i) begin
                        secreq_q  <= 1'b0;
                        state_q   <= S_NEXT;
                    end else if (tmo_hit) begin
                        secreq_q  <= 1'b0;
                        sdtmo_q   <= 1'b1;
                        rpsdack_q <= ack_onehot;
                        state_q   <= S_ACK;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 24'd1;
                    end
                end

                S_NEXT: begin
                    if (rhWCZ_i) begin
                        rpsdack_q   <= ack_onehot;
                        state_q     <= S_ACK;
                    end else begin
                        sdincsect_q <= 1'b1;
                        seclsa_q    <= seclsa_q + 21'd1;
                        tmo_cnt_q   <= 24'd0;
                        secreq_q    <= 1'b1;
                        state_q     <= S_XFER;
                    end
                end

                S_ACK: begin
                    state_q <= S_RELEASE;
                end

                S_RELEASE: begin
                    // Step past the served drive so it cannot win twice in a row.
                    if (!req_sel) begin
                        sdscan_q   <= sdscan_q + 3'd1;
                        sdreadop_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign secREQ_o    = secreq_q;
    assign secOP_o     = secop_q;
    assign secLSA_o    = seclsa_q;
    assign rpSDACK_o   = rpsdack_q;
    assign sdSCAN_o    = sdscan_q;
    assign sdINCSECT_o = sdincsect_q;
    assign sdREADOP_o  = sdreadop_q;
    assign sdTMO_o     = sdtmo_q;

endmodule

// File: tb/tb_rp_sd_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rp_sd_arbiter
//
// Directed bench for rp_sd_arbiter with TIMEOUT=16. Inputs change one time
// unit after the rising edge and outputs are observed at the same point, so
// every observation sees settled registered values.
// -----------------------------------------------------------------------------
module tb_rp_sd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  sd_req;
    logic [2:0]  sd_op;
    logic [20:0] sd_lsa;
    logic        wcz;
    logic        sec_done;
    logic        sec_req;
    logic [2:0]  sec_op;
    logic [20:0] sec_lsa;
    logic [7:0]  sd_ack;
    logic [2:0]  sd_scan;
    logic        sd_incsect;
    logic        sd_readop;
    logic        sd_tmo;

    int checks   = 0;
    int failures = 0;

    rp_sd_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clr_i       (clr),
        .rpSDREQ_i   (sd_req),
        .rpSDOP_i    (sd_op),
        .rpSDLSA_i   (sd_lsa),
        .rhWCZ_i     (wcz),
        .secDONE_i   (sec_done),
        .secREQ_o    (sec_req),
        .secOP_o     (sec_op),
        .secLSA_o    (sec_lsa),
        .rpSDACK_o   (sd_ack),
        .sdSCAN_o    (sd_scan),
        .sdINCSECT_o (sd_incsect),
        .sdREADOP_o  (sd_readop),
        .sdTMO_o     (sd_tmo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_scan(input logic [2:0] d, input string tag);
        int n = 0;
        while (sd_scan !== d && n < 40) begin
            tick();
            n++;
        end
        check(tag, {29'd0, sd_scan}, {29'd0, d});
    endtask

    task automatic wait_secreq(input string tag);
        int n = 0;
        while (sec_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, sec_req}, 32'd1);
    endtask

    task automatic wait_ack(input logic [7:0] exp, input string tag);
        int n = 0;
        while (sd_ack === 8'd0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, {24'd0, sd_ack}, {24'd0, exp});
    endtask

    // One single-sector READ on drive d with the drive releasing on ack.
    task automatic serve(input logic [2:0] d, input bit reraise);
        logic [7:0] exp_ack;
        logic [2:0] next_d;
        exp_ack = 8'h01 << d;
        next_d  = d + 3'd1;
        wait_secreq("rr_secreq");
        check("rr_served_drive", {29'd0, sd_scan}, {29'd0, d});
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        wait_ack(exp_ack, "rr_ack");
        sd_req[d] = 1'b0;
        tick();
        tick();
        check("rr_scan_after", {29'd0, sd_scan}, {29'd0, next_d});
        if (reraise) sd_req[d] = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        sd_req   = 8'h00;
        sd_op    = 3'b000;
        sd_lsa   = 21'd0;
        wcz      = 1'b0;
        sec_done = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_scan",    {29'd0, sd_scan},    32'd0);
        check("rst_secreq",  {31'd0, sec_req},    32'd0);
        check("rst_ack",     {24'd0, sd_ack},     32'd0);
        check("rst_tmo",     {31'd0, sd_tmo},     32'd0);
        check("rst_readop",  {31'd0, sd_readop},  32'd0);
        check("rst_lsa",     {11'd0, sec_lsa},    32'd0);
        check("rst_op",      {29'd0, sec_op},     32'd0);
        check("rst_incsect", {31'd0, sd_incsect}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("scan_increments", {29'd0, sd_scan}, 32'd1);

        // Single-sector READ on drive 2.
        sd_req = 8'h04;
        sd_op  = 3'b001;
        sd_lsa = 21'h000100;
        wcz    = 1'b1;
        wait_scan(3'd2, "rd_scan");
        tick();
        check("rd_latch_secreq", {31'd0, sec_req},   32'd0);
        check("rd_latch_lsa",    {11'd0, sec_lsa},   32'h100);
        check("rd_latch_op",     {29'd0, sec_op},    32'd1);
        check("rd_latch_readop", {31'd0, sd_readop}, 32'd1);
        tick();
        check("rd_secreq_rise", {31'd0, sec_req}, 32'd1);
        tick();
        tick();
        check("rd_secreq_held", {31'd0, sec_req}, 32'd1);
        check("rd_scan_stable", {29'd0, sd_scan}, 32'd2);
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        check("rd_secreq_drop", {31'd0, sec_req}, 32'd0);
        check("rd_no_early_ack", {24'd0, sd_ack}, 32'd0);
        tick();
        check("rd_ack",        {24'd0, sd_ack},    32'h04);
        check("rd_ack_readop", {31'd0, sd_readop}, 32'd1);
        sd_req = 8'h00;
        tick();
        check("rd_ack_one_cycle", {24'd0, sd_ack},    32'd0);
        check("rd_release_readop", {31'd0, sd_readop}, 32'd1);
        tick();
        check("rd_scan_next",   {29'd0, sd_scan},   32'd3);
        check("rd_readop_idle", {31'd0, sd_readop}, 32'd0);

        // A completion pulse outside XFER has no effect.
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        check("stray_done_secreq",  {31'd0, sec_req},    32'd0);
        check("stray_done_incsect", {31'd0, sd_incsect}, 32'd0);

        // Multi-sector WRITE on drive 5 wrapping the sector address.
        sd_req = 8'h20;
        sd_op  = 3'b010;
        sd_lsa = 21'h1FFFFF;
        wcz    = 1'b0;
        wait_scan(3'd5, "wr_scan");
        tick();
        check("wr_latch_lsa",    {11'd0, sec_lsa},   32'h1FFFFF);
        check("wr_latch_readop", {31'd0, sd_readop}, 32'd0);
        tick();
        check("wr_secreq_rise", {31'd0, sec_req}, 32'd1);
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        check("wr_next1_incsect", {31'd0, sd_incsect}, 32'd0);
        tick();
        check("wr_incsect1",   {31'd0, sd_incsect}, 32'd1);
        check("wr_lsa_wrap",   {11'd0, sec_lsa},    32'h000000);
        check("wr_secreq_re1", {31'd0, sec_req},    32'd1);
        tick();
        check("wr_incsect1_pulse", {31'd0, sd_incsect}, 32'd0);
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        tick();
        check("wr_incsect2", {31'd0, sd_incsect}, 32'd1);
        check("wr_lsa_1",    {11'd0, sec_lsa},    32'h000001);
        check("wr_no_ack",   {24'd0, sd_ack},     32'd0);
        wcz = 1'b1;
        tick();
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        tick();
        check("wr_ack",        {24'd0, sd_ack},     32'h20);
        check("wr_final_lsa",  {11'd0, sec_lsa},    32'h000001);
        check("wr_no_incsect", {31'd0, sd_incsect}, 32'd0);
        check("wr_readop",     {31'd0, sd_readop},  32'd0);
        sd_req = 8'h00;
        tick();
        check("wr_single_ack", {24'd0, sd_ack}, 32'd0);
        tick();
        check("wr_scan_next", {29'd0, sd_scan}, 32'd6);

        // Illegal op on drive 3: acknowledged without a sector request.
        sd_req = 8'h08;
        sd_op  = 3'b111;
        wait_scan(3'd3, "ill_scan");
        tick();
        check("ill_latch_op",     {29'd0, sec_op},  32'd7);
        check("ill_latch_secreq", {31'd0, sec_req}, 32'd0);
        tick();
        check("ill_ack",    {24'd0, sd_ack},    32'h08);
        check("ill_secreq", {31'd0, sec_req},   32'd0);
        check("ill_readop", {31'd0, sd_readop}, 32'd0);
        sd_req = 8'h00;
        tick();
        tick();
        check("ill_scan_next", {29'd0, sd_scan}, 32'd4);

        // Round-robin between drives 0 and 7 starting from scan 0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("rr_clr_scan", {29'd0, sd_scan}, 32'd0);
        sd_req = 8'h81;
        sd_op  = 3'b001;
        wcz    = 1'b1;
        serve(3'd0, 1'b1);
        serve(3'd7, 1'b1);
        serve(3'd0, 1'b0);
        sd_req = 8'h00;

        // Completion in the same cycle as the timeout wins.
        sd_req = 8'h04;
        sd_op  = 3'b010;
        wait_secreq("race_secreq");
        for (int i = 0; i < 15; i++) tick();
        check("race_pre_secreq", {31'd0, sec_req}, 32'd1);
        sec_done = 1'b1;
        tick();
        sec_done = 1'b0;
        check("race_tmo",    {31'd0, sd_tmo},  32'd0);
        check("race_secreq", {31'd0, sec_req}, 32'd0);
        tick();
        check("race_ack",     {24'd0, sd_ack}, 32'h04);
        check("race_tmo_ack", {31'd0, sd_tmo}, 32'd0);
        sd_req = 8'h00;
        tick();
        tick();

        // Timeout after 16 XFER cycles with no completion.
        sd_req = 8'h04;
        wait_secreq("tmo_secreq");
        for (int i = 0; i < 15; i++) tick();
        check("tmo_not_yet",    {31'd0, sd_tmo},  32'd0);
        check("tmo_secreq_16",  {31'd0, sec_req}, 32'd1);
        tick();
        check("tmo_set",        {31'd0, sd_tmo},  32'd1);
        check("tmo_ack",        {24'd0, sd_ack},  32'h04);
        check("tmo_secreq_low", {31'd0, sec_req}, 32'd0);
        sd_req = 8'h00;
        tick();
        tick();
        tick();
        check("tmo_sticky", {31'd0, sd_tmo}, 32'd1);
        check("tmo_ack_gone", {24'd0, sd_ack}, 32'd0);

        // clr during XFER of drive 1 aborts with no acknowledge.
        sd_req = 8'h02;
        sd_op  = 3'b001;
        sd_lsa = 21'h0ABCDE;
        wcz    = 1'b0;
        wait_secreq("clr_secreq");
        tick();
        check("clr_pre_readop", {31'd0, sd_readop}, 32'd1);
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        sd_req = 8'h00;
        check("clr_scan",    {29'd0, sd_scan},    32'd0);
        check("clr_secreq",  {31'd0, sec_req},    32'd0);
        check("clr_ack",     {24'd0, sd_ack},     32'd0);
        check("clr_tmo",     {31'd0, sd_tmo},     32'd0);
        check("clr_readop",  {31'd0, sd_readop},  32'd0);
        check("clr_lsa",     {11'd0, sec_lsa},    32'd0);
        check("clr_op",      {29'd0, sec_op},     32'd0);
        check("clr_incsect", {31'd0, sd_incsect}, 32'd0);
        tick();
        check("clr_no_late_ack", {24'd0, sd_ack},  32'd0);
        check("clr_scan_resume", {29'd0, sd_scan}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
